// File: rtl/output_buffer.sv
// Output buffer: circular FIFO between the CPU output strobe and a host/display consumer.
// Optional sticky overflow flag is enabled by defining OUTPUT_BUFFER_OVF_FLAG_EN.
module output_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         O,
    input  logic                     OEnable,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     ovf,
    input  logic                     clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             valid_r;
    logic             full_r;
    logic             pop_s;
    logic             push_s;
    logic [CW-1:0]    count_next_s;

    // Handshake decode; a pop on a full buffer frees the slot for a same-cycle push
    always_comb begin
        pop_s  = valid_r && dout_ready;
        push_s = OEnable && (!full_r || pop_s);
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and status flags; valid/full are registered from the next count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    // Storage array; contents are left alone by reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && !clr && push_s) begin
            mem_r[wr_ptr_r] <= O;
        end
    end

    // First-word-fall-through head, forced to zero while empty
    always_comb begin
        if (valid_r) begin
            dout = mem_r[rd_ptr_r];
        end else begin
            dout = {WIDTH{1'b0}};
        end
    end

    assign dout_valid = valid_r;
    assign count      = count_r;
    assign full       = full_r;

`ifdef OUTPUT_BUFFER_OVF_FLAG_EN
    logic ovf_r;

    // Sticky overflow: set by any strobe dropped against a full buffer
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf_r <= 1'b0;
        end else if (OEnable && full_r && !pop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: queue-based reference model checked every cycle,
// plus directed literal expectations for the key scenarios.
module tb_output_buffer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] O = 8'h00;
    logic             OEnable = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic [3:0]       count;
    logic             full;
    logic             ovf;
    logic             clr = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic             ovf_m = 1'b0;

    output_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .O(O), .OEnable(OEnable), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .count(count),
        .full(full), .ovf(ovf), .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output against it.
    task automatic step(input logic [7:0] o_v, input logic oe_v, input logic rdy_v,
                        input logic clr_v, input logic rst_v);
        bit pop;
        bit push;
        O = o_v; OEnable = oe_v; dout_ready = rdy_v; clr = clr_v; rst = rst_v;
        @(posedge clk);
        if (rst_v || clr_v) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            pop  = (q.size() > 0) && rdy_v;
            push = oe_v && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(o_v);
`ifdef OUTPUT_BUFFER_OVF_FLAG_EN
            if (oe_v && !push) ovf_m = 1'b1;
`endif
        end
        #1;
        check("model_count", {28'd0, count}, q.size());
        check("model_valid", {31'd0, dout_valid}, {31'd0, q.size() > 0});
        check("model_full", {31'd0, full}, {31'd0, q.size() == DEPTH});
        check("model_dout", {24'd0, dout}, (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
        check("model_ovf", {31'd0, ovf}, {31'd0, ovf_m});
        O = 8'h00; OEnable = 1'b0; dout_ready = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_count", {28'd0, count}, 32'd0);
        check("reset_dout", {24'd0, dout}, 32'd0);

        // Push into empty buffer appears right after the edge
        step(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        check("first_dout", {24'd0, dout}, 32'h0F);
        check("first_valid", {31'd0, dout_valid}, 32'd1);
        check("first_count", {28'd0, count}, 32'd1);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("first_drain", {28'd0, count}, 32'd0);

        // Ready while empty is ignored; empty with push+ready pushes only
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        check("empty_push_rdy", {28'd0, count}, 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Fill then drain in order
        for (int i = 0; i < DEPTH; i++) step(8'h01 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {28'd0, count}, 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_seq", {24'd0, dout}, 32'h01 + i);
            step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_valid", {31'd0, dout_valid}, 32'd0);
        check("drain_dout", {24'd0, dout}, 32'd0);

        // Fill again, drop AA, then push BB with simultaneous pop
        for (int i = 0; i < DEPTH; i++) step(8'h01 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        check("drop_count", {28'd0, count}, 32'd8);
        check("drop_head", {24'd0, dout}, 32'h01);
`ifdef OUTPUT_BUFFER_OVF_FLAG_EN
        check("drop_ovf", {31'd0, ovf}, 32'd1);
`else
        check("drop_ovf", {31'd0, ovf}, 32'd0);
`endif
        step(8'hBB, 1'b1, 1'b1, 1'b0, 1'b0);
        check("full_pp_count", {28'd0, count}, 32'd8);
        check("full_pp_head", {24'd0, dout}, 32'h02);
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == DEPTH - 1) ? 8'hBB : 8'h02 + 8'(i);
            check("bb_drain_seq", {24'd0, dout}, {24'd0, v});
            step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("bb_empty", {31'd0, dout_valid}, 32'd0);

        // Streaming push/pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            check("stream_dout", {24'd0, dout}, i);
            check("stream_count", {28'd0, count}, 32'd1);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stream_end", {28'd0, count}, 32'd0);

        // Three queued words with overflow, cleared by clr then by rst, each with OEnable high
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH + 1; i++) step(8'h30 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < DEPTH - 3; i++) step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            check("pre_clr_count", {28'd0, count}, 32'd3);
            if (pass == 0) step(8'hCC, 1'b1, 1'b1, 1'b1, 1'b0);
            else           step(8'hCC, 1'b1, 1'b1, 1'b1, 1'b1);
            check("clr_count", {28'd0, count}, 32'd0);
            check("clr_valid", {31'd0, dout_valid}, 32'd0);
            check("clr_ovf", {31'd0, ovf}, 32'd0);
            check("clr_dout", {24'd0, dout}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-002 Parameter: WIDTH, default 8, data width; matches CPU output bus O.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: O  input  WIDTH  CPU output data bus.
REQ-006 Port: OEnable  input  1  CPU output strobe; one write per cycle high.
REQ-007 Port: dout  output  WIDTH  head-of-queue data to host/display.
REQ-008 Port: dout_valid  output  1  high when queue non-empty.
REQ-009 Port: dout_ready  input  1  consumer accept; pop occurs when dout_valid && dout_ready.
REQ-010 Port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 Port: full  output  1  high when count == DEPTH.
REQ-012 Port: ovf  output  1  sticky overflow flag (see Configuration).
REQ-013 Port: clr  input  1  synchronous flush of queue and ovf; same effect as rst.

Function
REQ-014 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-015 Push SHALL occur on an edge where OEnable=1 and (full=0 or a pop occurs in the same cycle); O stored at write pointer, write pointer advances.
REQ-016 OEnable=1 with full=1 and no same-cycle pop SHALL drop O; contents, pointers and count unchanged.
REQ-017 Output SHALL be first-word-fall-through: dout = entry at read pointer whenever dout_valid=1, dout = 0 when dout_valid=0.
REQ-018 Latency: a word pushed into an empty buffer at edge N SHALL appear on dout with dout_valid=1 immediately after edge N.
REQ-019 Empty buffer with OEnable=1 and dout_ready=1 SHALL push only; no pop, no bypass.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-021 dout_ready while dout_valid=0 SHALL be ignored.
REQ-022 count, full, dout_valid SHALL be derived from registered state only, no combinational path from OEnable or dout_ready.
REQ-023 Order SHALL be strict FIFO; no word duplicated or reordered across pointer wrap-around.
REQ-024 clr=1 SHALL take priority over push/pop in the same cycle.

Reset
REQ-025 On rst=1 at a rising edge: pointers=0, count=0, dout_valid=0, dout=0, full=0, ovf=0.
REQ-026 rst mid-operation SHALL discard all queued words; storage array need not be cleared.
REQ-027 rst SHALL take priority over clr, OEnable and dout_ready.

Configuration
REQ-028 Macro OUTPUT_BUFFER_OVF_FLAG_EN: when defined, ovf SHALL set on any dropped push (REQ-016) and hold until rst or clr.
REQ-029 Without OUTPUT_BUFFER_OVF_FLAG_EN, ovf SHALL be constant 0 and no overflow register is synthesized; drop behaviour unchanged.

Verification
REQ-030 Reset, then OEnable pulse with O=8'h0F -> next cycle dout=8'h0F, dout_valid=1, count=1.
REQ-031 Push 8'h01..8'h08 with dout_ready=0 -> full=1, count=8; drain with dout_ready=1 -> dout sequence 01..08, then dout_valid=0, dout=0.
REQ-032 Full buffer, push 8'hAA with dout_ready=0 -> 8'hAA dropped, count=8, ovf=1 (macro defined) / ovf=0 (undefined).
REQ-033 Full buffer, push 8'hBB with dout_ready=1 same cycle -> count stays 8, 8'h01 popped, 8'hBB emerges last.
REQ-034 Continuous push/pop for 20 words 8'h00..8'h13 across wrap -> output identical order, count never exceeds 1.
REQ-035 Three words queued, ovf=1, then rst (or clr) with OEnable=1 -> count=0, dout_valid=0, ovf=0, pushed word discarded.
